cordic_rr_scheduler: RTL
========================

Name: cordic_rr_scheduler

Overview:
- Shares one pipelined rotational CORDIC (x, y, theta in; xprime, yprime, done-strobe out) between NREQ requesters.
- Round-robin arbitration; one operation issued per cycle maximum.
- An ordered tag FIFO records which requester owns each in-flight operation, so every result is steered back to its owner.
- Sits between the vector-rotation clients and the CORDIC core; the core's result-valid output (data_out_rot) drives cordic_done.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 16, data width; Q2.14 (16384 = 1.0), theta in radians Q2.14.
- MAX_OUT, 8, maximum in-flight operations = tag FIFO depth; power of 2, >= CORDIC latency for full throughput.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request.
- req_ready  out  NREQ  one-hot grant; handshake when req_valid[i] & req_ready[i].
- req_x, req_y, req_theta  in  NREQ*W each  packed operands; requester i occupies bits [i*W +: W].
- cordic_start  out  1  issue strobe to CORDIC.
- cordic_x, cordic_y, cordic_theta  out  W each  operands to CORDIC.
- cordic_xprime, cordic_yprime  in  W each  CORDIC results.
- cordic_done  in  1  CORDIC result valid, one cycle per operation, in issue order.
- rsp_valid  out  NREQ  one-hot result strobe to owner.
- rsp_xprime, rsp_yprime  out  W each  result data, shared bus.
- busy  out  1  tag FIFO non-empty.
- err_orphan  out  1  sticky; cordic_done seen with empty tag FIFO.

Behaviour:
- Reset (reset = 0, asynchronous): every output = 0, FIFO count = 0, RR pointer = 0 (requester 0 highest priority), err_orphan = 0. In-flight tags are discarded; results arriving after release with an empty FIFO are dropped and set err_orphan.
- Arbitration (combinational req_ready):
  - Grant allowed only when count < MAX_OUT.
  - Winner is the first asserted req_valid scanning from the RR pointer upward, with wrap-around.
  - req_ready is 0 for all requesters when no grant is allowed.
- Grant cycle (registered on the clock edge):
  - RR pointer <= winner + 1 (mod NREQ).
  - Winner index pushed to the tag FIFO.
  - cordic_start <= 1 and cordic_x/y/theta <= the winner's operands; issue latency = 1 cycle.
  - No grant: cordic_start <= 0; cordic_x/y/theta hold their values.
- Back-to-back: a requester holding req_valid with no contenders is granted every cycle until the credit limit.
- Result path (registered):
  - On cordic_done with count > 0: pop the head tag; next cycle rsp_valid <= one-hot(tag), rsp_xprime/rsp_yprime <= cordic_xprime/cordic_yprime.
  - Otherwise rsp_valid <= 0 and the data holds.
  - Results pass through unmodified; no backpressure on rsp_*.
- Simultaneous push and pop: count unchanged; pop reads the old head. At count = MAX_OUT with cordic_done, grant is still blocked that cycle and reopens the next cycle.
- Pointers: FIFO read/write pointers wrap modulo MAX_OUT. count width is clog2(MAX_OUT)+1.
- busy = (count != 0), registered.
- err_orphan: set on cordic_done with count = 0; cleared only by reset.
- req_valid may drop without a handshake; the scheduler holds no per-request state before grant.

Test Plan:
- Single request: reset 0 -> 1; req_valid = 0010 with (16384, 16384, 8579).
  - Required: req_ready = 0010 the same cycle; cordic_start pulses 1 cycle later with 16384/16384/8579.
  - The bench's CORDIC model (latency 4) returns (5997, 22381); rsp_valid = 0010 one cycle after cordic_done, rsp = 5997/22381.
- Contention: all 4 requesters valid for 8 cycles, operands (i*1000, 0, 0).
  - Required grant order: 0, 1, 2, 3, 0, 1, 2, 3.
  - rsp_valid order is identical; each rsp_xprime matches its issuer's model result.
- Credit limit: MAX_OUT = 8, CORDIC model latency 12, req 0 held valid.
  - Required: exactly 8 starts, then req_ready = 0 until the first cordic_done; busy = 1 throughout; count never exceeds 8.
- Same-cycle grant and pop at count = 5: count stays 5, no lost or duplicated tag, ownership order preserved.
- Reset mid-flight: 3 ops in flight, reset = 0 for 1 cycle.
  - Required: all outputs 0 immediately (asynchronous); count = 0.
  - A subsequent stray cordic_done is dropped with no rsp_valid and err_orphan = 1.
- Gap in requests: req 2 valid 1 cycle, idle 3 cycles, then req 1.
  - Required: grant order 2 then 1; RR pointer = 3 after the first grant; cordic_start deasserts during idle with operands held.

Source files
------------

// File: rtl/cordic_rr_scheduler.sv
// Round-robin front end that shares one pipelined rotational CORDIC between NREQ
// requesters and uses an in-order tag FIFO to steer each result back to its owner.
module cordic_rr_scheduler #(
  parameter int NREQ    = 4,
  parameter int W       = 16,
  parameter int MAX_OUT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_x,
  input  logic [NREQ*W-1:0] req_y,
  input  logic [NREQ*W-1:0] req_theta,
  output logic              cordic_start,
  output logic [W-1:0]      cordic_x,
  output logic [W-1:0]      cordic_y,
  output logic [W-1:0]      cordic_theta,
  input  logic [W-1:0]      cordic_xprime,
  input  logic [W-1:0]      cordic_yprime,
  input  logic              cordic_done,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [W-1:0]      rsp_xprime,
  output logic [W-1:0]      rsp_yprime,
  output logic              busy,
  output logic              err_orphan
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [IDX_W-1:0] tag_mem_q [MAX_OUT];
  logic [IDX_W-1:0] tag_mem_d [MAX_OUT];

  logic             cordic_start_q, cordic_start_d;
  logic [W-1:0]     cordic_x_q, cordic_x_d;
  logic [W-1:0]     cordic_y_q, cordic_y_d;
  logic [W-1:0]     cordic_theta_q, cordic_theta_d;
  logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [W-1:0]     rsp_xprime_q, rsp_xprime_d;
  logic [W-1:0]     rsp_yprime_q, rsp_yprime_d;
  logic             busy_q, busy_d;
  logic             err_orphan_q, err_orphan_d;

  logic             grant_ok;
  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W:0]   scan_sum;
  logic [IDX_W-1:0] scan_idx;
  logic             grant;
  logic             pop;
  logic             orphan;
  logic [W-1:0]     win_x, win_y, win_theta;

  // Credit check; reset is folded in so req_ready is low while reset is held.
  assign grant_ok = reset && (count_q < CNT_W'(MAX_OUT));

  // Scan from the round-robin pointer upward with wrap-around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      scan_sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
      if (scan_sum >= (IDX_W+1)'(NREQ)) begin
        scan_sum = scan_sum - (IDX_W+1)'(NREQ);
      end
      scan_idx = scan_sum[IDX_W-1:0];
      if (!win_found && req_valid[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  assign grant     = grant_ok && win_found;
  assign req_ready = grant ? (NREQ'(1) << win_idx) : '0;

  always_comb begin
    win_x     = '0;
    win_y     = '0;
    win_theta = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win_idx == IDX_W'(i)) begin
        win_x     = req_x[i*W +: W];
        win_y     = req_y[i*W +: W];
        win_theta = req_theta[i*W +: W];
      end
    end
  end

  assign pop    = cordic_done && (count_q != '0);
  assign orphan = cordic_done && (count_q == '0);

  // Tag FIFO and round-robin pointer.
  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    tag_mem_d = tag_mem_q;
    if (grant) begin
      rr_ptr_d            = (win_idx == IDX_W'(NREQ-1)) ? '0 : win_idx + IDX_W'(1);
      tag_mem_d[wr_ptr_q] = win_idx;
      wr_ptr_d            = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({grant, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Issue and result registers.
  always_comb begin
    cordic_start_d = grant;
    cordic_x_d     = cordic_x_q;
    cordic_y_d     = cordic_y_q;
    cordic_theta_d = cordic_theta_q;
    rsp_valid_d    = '0;
    rsp_xprime_d   = rsp_xprime_q;
    rsp_yprime_d   = rsp_yprime_q;
    if (grant) begin
      cordic_x_d     = win_x;
      cordic_y_d     = win_y;
      cordic_theta_d = win_theta;
    end
    if (pop) begin
      rsp_valid_d  = NREQ'(1) << tag_mem_q[rd_ptr_q];
      rsp_xprime_d = cordic_xprime;
      rsp_yprime_d = cordic_yprime;
    end
    busy_d       = (count_d != '0);
    err_orphan_d = err_orphan_q || orphan;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      tag_mem_q      <= '{default: '0};
      cordic_start_q <= 1'b0;
      cordic_x_q     <= '0;
      cordic_y_q     <= '0;
      cordic_theta_q <= '0;
      rsp_valid_q    <= '0;
      rsp_xprime_q   <= '0;
      rsp_yprime_q   <= '0;
      busy_q         <= 1'b0;
      err_orphan_q   <= 1'b0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      tag_mem_q      <= tag_mem_d;
      cordic_start_q <= cordic_start_d;
      cordic_x_q     <= cordic_x_d;
      cordic_y_q     <= cordic_y_d;
      cordic_theta_q <= cordic_theta_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_xprime_q   <= rsp_xprime_d;
      rsp_yprime_q   <= rsp_yprime_d;
      busy_q         <= busy_d;
      err_orphan_q   <= err_orphan_d;
    end
  end

  assign cordic_start = cordic_start_q;
  assign cordic_x     = cordic_x_q;
  assign cordic_y     = cordic_y_q;
  assign cordic_theta = cordic_theta_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_xprime   = rsp_xprime_q;
  assign rsp_yprime   = rsp_yprime_q;
  assign busy         = busy_q;
  assign err_orphan   = err_orphan_q;

endmodule
